writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
Write-back stage and register file of the RISC pipeline: the producer end of the operand buses that feed MUXAB. It latches EX-stage results into a WB pipeline register, selects the write-back value (MUX D), writes it to a 32x32 register file, and supplies read data (dataA/dataB) plus the WB forwarding value (dataD) back to operand selection. Read ports bypass the in-flight write so operands are never stale.

Parameters:
DATA_W, 32, register/bus width
ADDR_W, 5, register address width (2^ADDR_W registers)
PC_W, 10, width of PC+1 link value

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  hold WB pipeline register (no capture)
ex_rw  in  1  EX-stage register-write request
ex_da  in  ADDR_W  EX-stage destination register
ex_md  in  2  MUX D select: 00 F, 01 memory, 10 set-less-than, 11 link
ex_f  in  DATA_W  function-unit result
ex_mem  in  DATA_W  data-memory read data
ex_n  in  1  function-unit negative flag
ex_v  in  1  function-unit overflow flag
ex_pc1  in  PC_W  PC+1 of the EX instruction
aa  in  ADDR_W  read address A
ba  in  ADDR_W  read address B
dataA  out  DATA_W  register read A (bypassed)
dataB  out  DATA_W  register read B (bypassed)
dataD  out  DATA_W  current WB value, forwarded to MUXAB
wb_rw  out  1  qualified WB write enable (for hazard/forward logic)
wb_da  out  ADDR_W  WB destination register

Behaviour:
- Reset (async, active-high): R0..R31 = 0; WB register cleared: wb_rw=0, wb_da=0, md=00, f/mem/n/v/pc1=0. Hence dataD=0, dataA=dataB=0 while reset held. A write pending in WB at reset assertion is discarded.
- WB capture: on rising clk with stall=0, WB register <= {ex_rw && (ex_da!=0), ex_da, ex_md, ex_f, ex_mem, ex_n, ex_v, ex_pc1}. With stall=1 the WB register holds every field.
- wb_rw/wb_da: driven directly from WB register (registered, no combinational path from ex_*).
- MUX D (combinational from WB register): 00 -> f; 01 -> mem; 10 -> {(DATA_W-1) zeros, n XOR v}; 11 -> {(DATA_W-PC_W) zeros, pc1}. dataD = MUX D output at all times, independent of wb_rw.
- Register write: on rising clk, if wb_rw=1 then R[wb_da] <= dataD. One-cycle latency EX-capture -> WB visible on dataD; write committed at the following edge. During stall the same write repeats each cycle (idempotent).
- R0: never written (wb_rw qualified at capture); reads of address 0 return 0 regardless of bypass.
- Reads: combinational. dataA = 0 if aa==0; else dataD if wb_rw && wb_da==aa; else R[aa]. dataB identical with ba. aa==ba is legal; both ports return the same value.
- Simultaneous capture and write at one edge: write uses the old WB contents; the new EX contents only appear on dataD after the edge.
- No X propagation: every register has a defined reset value; ex_md fully decoded.

Test Plan:
- Reset: assert reset mid-cycle with wb_rw=1, wb_da=5 -> immediately dataD=0, wb_rw=0; after release, read aa=5 returns 0 (write discarded).
- ALU write-back: ex_rw=1, ex_da=3, ex_md=00, ex_f=0xDEADBEEF, one edge -> wb_rw=1, wb_da=3, dataD=0xDEADBEEF, aa=3 gives dataA=0xDEADBEEF via bypass; after next edge (ex_rw=0) aa=3 still 0xDEADBEEF from R3.
- MUX D sources: md=01 mem=0x12345678 -> dataD=0x12345678; md=10 n=1 v=0 -> 0x00000001; n=1 v=1 -> 0x00000000; md=11 pc1=0x3FF -> 0x000003FF.
- R0 protection: ex_rw=1, ex_da=0, ex_f=0xFFFFFFFF -> wb_rw=0; aa=0, ba=0 -> dataA=dataB=0 on all cycles.
- Stall: capture R7<=0xA5A5A5A5, then stall=1 for 3 cycles while ex_f=0x11111111, ex_da=8 -> wb_da stays 7, dataD stays 0xA5A5A5A5, R8 unchanged (0); release stall -> R8 written 0x11111111 one edge later.
- Back-to-back same register: writes R4<=1 then R4<=2 on consecutive cycles -> aa=4 reads 1 in first WB cycle, 2 in second (bypass), 2 afterwards from R4.

Source files
------------

// File: rtl/writeback_regfile.sv
// Write-back stage: WB pipeline register, MUX D result select and a 2^ADDR_W x DATA_W
// register file whose read ports bypass the write currently held in WB.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_rw,
  input  logic [ADDR_W-1:0] ex_da,
  input  logic [1:0]        ex_md,
  input  logic [DATA_W-1:0] ex_f,
  input  logic [DATA_W-1:0] ex_mem,
  input  logic              ex_n,
  input  logic              ex_v,
  input  logic [PC_W-1:0]   ex_pc1,
  input  logic [ADDR_W-1:0] aa,
  input  logic [ADDR_W-1:0] ba,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] dataD,
  output logic              wb_rw,
  output logic [ADDR_W-1:0] wb_da
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        md_q;
  logic [DATA_W-1:0] f_q;
  logic [DATA_W-1:0] mem_q;
  logic              n_q;
  logic              v_q;
  logic [PC_W-1:0]   pc1_q;
  logic [DATA_W-1:0] regs [NREG];

  // Writes to R0 are dropped here, so nothing downstream has to special-case address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rw <= 1'b0;
      wb_da <= '0;
      md_q  <= '0;
      f_q   <= '0;
      mem_q <= '0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      pc1_q <= '0;
    end else if (!stall) begin
      wb_rw <= ex_rw && (ex_da != '0);
      wb_da <= ex_da;
      md_q  <= ex_md;
      f_q   <= ex_f;
      mem_q <= ex_mem;
      n_q   <= ex_n;
      v_q   <= ex_v;
      pc1_q <= ex_pc1;
    end
  end

  always_comb begin
    dataD = f_q;
    case (md_q)
      2'b00:   dataD = f_q;
      2'b01:   dataD = mem_q;
      2'b10:   dataD = {{(DATA_W-1){1'b0}}, n_q ^ v_q};
      default: dataD = {{(DATA_W-PC_W){1'b0}}, pc1_q};
    endcase
  end

  // A stalled WB repeats the same write every cycle, which is harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_rw) begin
      regs[wb_da] <= dataD;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)
      return '0;
    else if (wb_rw && (wb_da == addr))
      return dataD;
    else
      return regs[addr];
  endfunction

  always_comb begin
    dataA = read_port(aa);
    dataB = read_port(ba);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios then random traffic, all checked
// against an architectural model (register array plus the one write in flight).
module tb_writeback_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 10;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              ex_rw;
  logic [ADDR_W-1:0] ex_da;
  logic [1:0]        ex_md;
  logic [DATA_W-1:0] ex_f;
  logic [DATA_W-1:0] ex_mem;
  logic              ex_n;
  logic              ex_v;
  logic [PC_W-1:0]   ex_pc1;
  logic [ADDR_W-1:0] aa;
  logic [ADDR_W-1:0] ba;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic [DATA_W-1:0] dataD;
  logic              wb_rw;
  logic [ADDR_W-1:0] wb_da;

  writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_rw(ex_rw), .ex_da(ex_da), .ex_md(ex_md), .ex_f(ex_f), .ex_mem(ex_mem),
    .ex_n(ex_n), .ex_v(ex_v), .ex_pc1(ex_pc1),
    .aa(aa), .ba(ba), .dataA(dataA), .dataB(dataB), .dataD(dataD),
    .wb_rw(wb_rw), .wb_da(wb_da)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_regs [32];
  logic              m_rw;
  logic [ADDR_W-1:0] m_da;
  logic [DATA_W-1:0] exp_q [$];   // value sitting in WB (always one entry)

  int errors = 0;
  int checks = 0;

  function automatic logic [DATA_W-1:0] wb_value(input logic [1:0] md,
      input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] mem,
      input logic n, input logic v, input logic [PC_W-1:0] pc1);
    case (md)
      2'd0:    return f;
      2'd1:    return mem;
      2'd2:    return (n != v) ? 32'd1 : 32'd0;
      default: return 32'(pc1);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return 0;
    if (m_rw && m_da == a) return exp_q[0];
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_rw = 1'b0;
    m_da = 0;
    exp_q = {32'h0};
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ex(input logic rw, input logic [ADDR_W-1:0] da, input logic [1:0] md,
      input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] mem,
      input logic n, input logic v, input logic [PC_W-1:0] pc1);
    ex_rw = rw; ex_da = da; ex_md = md; ex_f = f; ex_mem = mem;
    ex_n = n; ex_v = v; ex_pc1 = pc1;
  endtask

  // One rising edge; the model commits the old WB write, then captures EX.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (m_rw) m_regs[m_da] = exp_q[0];
      if (!stall) begin
        m_rw = ex_rw && (ex_da != 0);
        m_da = ex_da;
        exp_q = {wb_value(ex_md, ex_f, ex_mem, ex_n, ex_v, ex_pc1)};
      end
    end
    #1;
  endtask

  task automatic probe(input string tag, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    aa = a;
    ba = b;
    #1;
    check({tag, "_dataD"}, dataD, exp_q[0]);
    check({tag, "_wb_rw"}, 32'(wb_rw), 32'(m_rw));
    check({tag, "_wb_da"}, 32'(wb_da), 32'(m_da));
    check({tag, "_dataA"}, dataA, model_read(a));
    check({tag, "_dataB"}, dataB, model_read(b));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    aa = 0;
    ba = 0;
    drive_ex(1'b0, 0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    model_reset();
    #2;
    probe("reset_hold", 5'd5, 5'd0);
    check("reset_dataD_zero", dataD, 32'h0);
    #4 reset = 1'b0;

    // ALU result with bypass, then from the register file
    drive_ex(1'b1, 5'd3, 2'd0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);
    tick();
    probe("alu_bypass", 5'd3, 5'd0);
    check("alu_bypass_const", dataA, 32'hDEADBEEF);
    drive_ex(1'b0, 5'd0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    tick();
    probe("alu_reg", 5'd3, 5'd3);
    check("alu_reg_const", dataA, 32'hDEADBEEF);

    // MUX D sources
    drive_ex(1'b1, 5'd9, 2'd1, 32'h0, 32'h12345678, 1'b0, 1'b0, 0);
    tick();
    check("md_mem", dataD, 32'h12345678);
    drive_ex(1'b1, 5'd10, 2'd2, 32'hFFFF0000, 0, 1'b1, 1'b0, 0);
    tick();
    check("md_slt_n1v0", dataD, 32'h1);
    drive_ex(1'b1, 5'd10, 2'd2, 32'hFFFF0000, 0, 1'b1, 1'b1, 0);
    tick();
    check("md_slt_n1v1", dataD, 32'h0);
    drive_ex(1'b1, 5'd11, 2'd3, 0, 0, 1'b0, 1'b0, 10'h3FF);
    tick();
    check("md_link", dataD, 32'h3FF);
    probe("md_link", 5'd9, 5'd10);

    // R0 is never written and always reads zero
    drive_ex(1'b1, 5'd0, 2'd0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 0);
    tick();
    check("r0_wb_rw", 32'(wb_rw), 32'h0);
    probe("r0_first", 5'd0, 5'd0);
    tick();
    probe("r0_second", 5'd0, 5'd0);
    check("r0_dataA", dataA, 32'h0);

    // Stall holds WB; R8 only written after release
    drive_ex(1'b1, 5'd7, 2'd0, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 0);
    tick();
    stall = 1'b1;
    drive_ex(1'b1, 5'd8, 2'd0, 32'h11111111, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      probe("stall", 5'd7, 5'd8);
      check("stall_wb_da", 32'(wb_da), 32'd7);
      check("stall_r8", dataB, 32'h0);
    end
    stall = 1'b0;
    tick();
    probe("unstall", 5'd8, 5'd7);
    check("unstall_r8", dataA, 32'h11111111);
    drive_ex(1'b0, 5'd0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    tick();
    probe("unstall_reg", 5'd8, 5'd7);

    // Back-to-back writes to the same register
    drive_ex(1'b1, 5'd4, 2'd0, 32'd1, 0, 1'b0, 1'b0, 0);
    tick();
    probe("b2b_1", 5'd4, 5'd4);
    check("b2b_1_const", dataA, 32'd1);
    drive_ex(1'b1, 5'd4, 2'd0, 32'd2, 0, 1'b0, 1'b0, 0);
    tick();
    probe("b2b_2", 5'd4, 5'd4);
    check("b2b_2_const", dataA, 32'd2);
    drive_ex(1'b0, 5'd0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    tick();
    tick();
    probe("b2b_reg", 5'd4, 5'd0);
    check("b2b_reg_const", dataA, 32'd2);

    // Reset mid-cycle discards a pending write
    drive_ex(1'b1, 5'd5, 2'd0, 32'hCAFEF00D, 0, 1'b0, 1'b0, 0);
    tick();
    check("pre_reset_wb_rw", 32'(wb_rw), 32'h1);
    check("pre_reset_wb_da", 32'(wb_da), 32'd5);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_dataD", dataD, 32'h0);
    check("async_reset_wb_rw", 32'(wb_rw), 32'h0);
    probe("async_reset", 5'd3, 5'd5);
    #1 reset = 1'b0;
    drive_ex(1'b0, 5'd0, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    tick();
    probe("post_reset", 5'd5, 5'd4);
    check("post_reset_r5", dataA, 32'h0);

    // Random traffic concentrated on a few registers so bypass hits are frequent
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      drive_ex(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(0, 1023)));
      tick();
      probe("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
